// File: rtl/poly_byte_encode.sv
// poly_byte_encode: streaming ByteEncode12 packer for Kyber768.
// Captures one 256-coefficient polynomial (16-bit storage, 12 significant
// bits) and emits its 384-byte serialization one byte per valid/ready
// transfer. Each coefficient pair (c0, c1) becomes three bytes:
//   c0[7:0], {c1[3:0], c0[11:8]}, c1[11:4]
// Optional feature macro: POLY_BYTE_ENCODE_REDUCE_EN
//   defined   : values in [Q, 2Q) are reduced by Q, err_range flags v >= 2Q
//   undefined : values packed as v[11:0], err_range flags v >= Q
module poly_byte_encode #(
    parameter int N       = 256,
    parameter int Q       = 3329,
    parameter int COEFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*COEFF_W-1:0] poly_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err_range
);

    localparam logic [15:0] Q_V      = 16'(Q);
    localparam logic [15:0] Q2_V     = 16'(2 * Q);
    localparam logic [6:0]  LAST_PAIR = 7'd127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Condition one stored coefficient: returns {out_of_range, packed 12 bits}.
    function automatic logic [12:0] cond_coef(input logic [15:0] v);
        logic [15:0] r;
        logic        oor;
`ifdef POLY_BYTE_ENCODE_REDUCE_EN
        if ((v >= Q_V) && (v < Q2_V)) begin
            r = v - Q_V;
        end else begin
            r = v;
        end
        oor = (v >= Q2_V);
`else
        r   = v;
        oor = (v >= Q_V);
`endif
        return {oor, r[11:0]};
    endfunction

    // Select the serialized byte for one phase of a coefficient pair.
    function automatic logic [7:0] pack_byte(input logic [11:0] c0,
                                             input logic [11:0] c1,
                                             input logic [1:0]  phase);
        logic [7:0] b;
        case (phase)
            2'd0:    b = c0[7:0];
            2'd1:    b = {c1[3:0], c0[11:8]};
            2'd2:    b = c1[11:4];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t               state_r;
    logic [N*COEFF_W-1:0] poly_r;
    logic [6:0]           pair_idx_r;
    logic [1:0]           byte_phase_r;
    logic                 out_valid_r;
    logic [7:0]           out_byte_r;
    logic                 out_last_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_range_r;

    // Next-byte selection from the captured register.
    logic [6:0]  sel_pair_s;
    logic [1:0]  sel_phase_s;
    logic [11:0] sel_base_s;
    logic [15:0] sel_c0_raw_s;
    logic [15:0] sel_c1_raw_s;
    logic [12:0] sel_c0_s;
    logic [12:0] sel_c1_s;
    logic [7:0]  sel_byte_s;
    logic        sel_err_s;
    logic        sel_last_s;
    logic        last_xfer_s;
    logic        xfer_s;

    // First byte taken straight from poly_in so byte 0 appears right after start.
    logic [12:0] st_c0_s;
    logic [12:0] st_c1_s;
    logic [7:0]  st_byte_s;
    logic        st_err_s;

    // Work out which pair/phase follows the one currently presented.
    always_comb begin
        sel_pair_s  = pair_idx_r;
        sel_phase_s = 2'd0;
        if (byte_phase_r == 2'd2) begin
            sel_pair_s  = pair_idx_r + 7'd1;
            sel_phase_s = 2'd0;
        end else begin
            sel_pair_s  = pair_idx_r;
            sel_phase_s = byte_phase_r + 2'd1;
        end
    end

    // Pick the next pair out of the captured polynomial and form its byte.
    always_comb begin
        sel_base_s   = {sel_pair_s, 5'd0};
        sel_c0_raw_s = poly_r[sel_base_s +: 16];
        sel_c1_raw_s = poly_r[(sel_base_s + 12'd16) +: 16];
        sel_c0_s     = cond_coef(sel_c0_raw_s);
        sel_c1_s     = cond_coef(sel_c1_raw_s);
        sel_byte_s   = pack_byte(sel_c0_s[11:0], sel_c1_s[11:0], sel_phase_s);
        sel_err_s    = sel_c0_s[12] | sel_c1_s[12];
        sel_last_s   = (sel_pair_s == LAST_PAIR) && (sel_phase_s == 2'd2);
    end

    // Pair 0 conditioning on the live input, used only when start is accepted.
    always_comb begin
        st_c0_s   = cond_coef(poly_in[15:0]);
        st_c1_s   = cond_coef(poly_in[31:16]);
        st_byte_s = pack_byte(st_c0_s[11:0], st_c1_s[11:0], 2'd0);
        st_err_s  = st_c0_s[12] | st_c1_s[12];
    end

    // Transfer handshake and end-of-stream detection.
    always_comb begin
        xfer_s      = out_valid_r && out_ready;
        last_xfer_s = (pair_idx_r == LAST_PAIR) && (byte_phase_r == 2'd2);
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            poly_r       <= '0;
            pair_idx_r   <= 7'd0;
            byte_phase_r <= 2'd0;
            out_valid_r  <= 1'b0;
            out_byte_r   <= 8'h00;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_range_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        poly_r       <= poly_in;
                        pair_idx_r   <= 7'd0;
                        byte_phase_r <= 2'd0;
                        out_valid_r  <= 1'b1;
                        out_byte_r   <= st_byte_s;
                        out_last_r   <= 1'b0;
                        busy_r       <= 1'b1;
                        err_range_r  <= st_err_s;
                        state_r      <= EMIT;
                    end
                end
                EMIT: begin
                    if (xfer_s) begin
                        if (last_xfer_s) begin
                            out_valid_r <= 1'b0;
                            out_byte_r  <= 8'h00;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            pair_idx_r   <= sel_pair_s;
                            byte_phase_r <= sel_phase_s;
                            out_byte_r   <= sel_byte_s;
                            out_last_r   <= sel_last_s;
                            // A new pair is range-checked only when first presented.
                            if (byte_phase_r == 2'd2) begin
                                err_range_r <= err_range_r | sel_err_s;
                            end
                        end
                    end
                end
                DONE: begin
                    done_r       <= 1'b0;
                    pair_idx_r   <= 7'd0;
                    byte_phase_r <= 2'd0;
                    state_r      <= IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_byte  = out_byte_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_range = err_range_r;

endmodule

// File: tb/tb_poly_byte_encode.sv
// Directed self-checking bench for poly_byte_encode.
`timescale 1ns/1ps
module tb_poly_byte_encode;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4095:0] poly;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_byte;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err_range;

    always #5 clk = ~clk;

    poly_byte_encode dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .poly_in   (poly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err_range (err_range)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] got   [384];
    logic [7:0] exp_b [384];
    int  got_n;
    int  done_cyc;
    int  stalls;
    bit  last_bad, stable_bad, busy_bad, after_bad, timeout;
    logic err1;

    function automatic logic [11:0] mred(input logic [15:0] v);
        logic [15:0] r;
`ifdef POLY_BYTE_ENCODE_REDUCE_EN
        r = ((v >= 16'd3329) && (v < 16'd6658)) ? v - 16'd3329 : v;
`else
        r = v;
`endif
        return r[11:0];
    endfunction

    function automatic logic [7:0] model_byte(input logic [4095:0] p, input int i);
        int pr = i / 3;
        int k  = i % 3;
        logic [11:0] c0 = mred(p[32*pr +: 16]);
        logic [11:0] c1 = mred(p[32*pr+16 +: 16]);
        if (k == 0) return c0[7:0];
        else if (k == 1) return {c1[3:0], c0[11:8]};
        else return c1[11:4];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_expected;
        for (int i = 0; i < 384; i++) exp_b[i] = model_byte(poly, i);
    endtask

    // Start one encode from an idle cycle and collect the stream.
    task automatic run_stream(input bit rnd, input bit poke_start);
        logic [7:0] prev_b;
        logic       prev_l;
        bit         prev_stall;
        int         c;
        got_n = 0; stalls = 0; done_cyc = -1;
        last_bad = 0; stable_bad = 0; busy_bad = 0; after_bad = 0; timeout = 0;
        prev_stall = 0; prev_b = 8'h00; prev_l = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        err1 = err_range;
        while (c < 5000 && done_cyc < 0) begin
            if (done) begin
                done_cyc = c;
                if (busy || out_valid) busy_bad = 1;
            end else begin
                if (!out_valid || !busy) busy_bad = 1;
                if (prev_stall && (out_byte !== prev_b || out_last !== prev_l)) stable_bad = 1;
                if (out_last !== (got_n == 383)) last_bad = 1;
                out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (poke_start) start = ($urandom_range(0, 3) == 0);
                if (out_ready) begin
                    if (got_n < 384) got[got_n] = out_byte;
                    got_n++;
                    prev_stall = 0;
                end else begin
                    stalls++;
                    prev_stall = 1;
                    prev_b = out_byte;
                    prev_l = out_last;
                end
                tick;
                c++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (done_cyc < 0) begin
            timeout = 1;
        end else begin
            tick;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) after_bad = 1;
        end
    endtask

    // Compare the collected stream with exp_b and check framing flags.
    task automatic check_stream(input string name, input int want_done);
        int nb = 0;
        int first = -1;
        total++;
        if (timeout) begin
            bad++;
            $display("FAIL %s_timeout no done within bound", name);
        end
        total++;
        if (got_n !== 384) begin
            bad++;
            $display("FAIL %s_count got=%0d want=384", name, got_n);
        end
        for (int i = 0; i < 384; i++) begin
            if (got[i] !== exp_b[i]) begin
                if (first < 0) first = i;
                nb++;
            end
        end
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL %s_bytes %0d wrong, first idx=%0d got=%02h want=%02h",
                     name, nb, first, got[first], exp_b[first]);
        end
        total++;
        if (done_cyc !== want_done) begin
            bad++;
            $display("FAIL %s_done_cycle got=%0d want=%0d", name, done_cyc, want_done);
        end
        total++;
        if (last_bad || busy_bad || after_bad) begin
            bad++;
            $display("FAIL %s_flags last_bad=%0d busy_bad=%0d after_bad=%0d want all 0",
                     name, last_bad, busy_bad, after_bad);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; poly = '0;
        #1;
        total++;
        if ({out_valid, out_byte, out_last, busy, done, err_range} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%013b want=0",
                     {out_valid, out_byte, out_last, busy, done, err_range});
        end
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_zero;
        poly = '0;
        fill_expected;
        run_stream(1'b0, 1'b0);
        check_stream("zero", 385);
        for (int i = 0; i < 384; i++) begin
            if (got[i] !== 8'h00) begin
                total++; bad++;
                $display("FAIL zero_const idx=%0d got=%02h want=00", i, got[i]);
                break;
            end
        end
        total++;
        if (err1 !== 1'b0 || err_range !== 1'b0) begin
            bad++;
            $display("FAIL zero_err got=%b/%b want=0", err1, err_range);
        end
    endtask

    task automatic set_ramp;
        for (int i = 0; i < 256; i++) poly[i*16 +: 16] = 16'(i);
    endtask

    task automatic test_ramp;
        logic [7:0] hand [9];
        int         idx  [9];
        hand = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h30, 8'h00, 8'hFE, 8'hF0, 8'h0F};
        idx  = '{0, 1, 2, 3, 4, 5, 381, 382, 383};
        set_ramp;
        fill_expected;
        run_stream(1'b0, 1'b0);
        check_stream("ramp", 385);
        for (int j = 0; j < 9; j++) begin
            total++;
            if (got[idx[j]] !== hand[j]) begin
                bad++;
                $display("FAIL ramp_hand idx=%0d got=%02h want=%02h", idx[j], got[idx[j]], hand[j]);
            end
        end
        total++;
        if (err_range !== 1'b0) begin
            bad++;
            $display("FAIL ramp_err got=%b want=0", err_range);
        end
    endtask

    task automatic test_const3328;
        logic [7:0] pat [3];
        int nb = 0;
        pat = '{8'h00, 8'h0D, 8'hD0};
        for (int i = 0; i < 256; i++) poly[i*16 +: 16] = 16'd3328;
        fill_expected;
        run_stream(1'b0, 1'b0);
        check_stream("c3328", 385);
        for (int i = 0; i < 384; i++) if (got[i] !== pat[i % 3]) nb++;
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL c3328_pattern wrong=%0d want=0 (byte0 got=%02h)", nb, got[0]);
        end
        total++;
        if (err_range !== 1'b0) begin
            bad++;
            $display("FAIL c3328_err got=%b want=0", err_range);
        end
    endtask

    task automatic test_backpressure;
        set_ramp;
        fill_expected;
        run_stream(1'b1, 1'b1);
        check_stream("bp", 385 + stalls);
        total++;
        if (stable_bad) begin
            bad++;
            $display("FAIL bp_stable out_byte/out_last changed during stall");
        end
    endtask

    task automatic test_range;
        logic [7:0] w0, w1;
        logic       we;
`ifdef POLY_BYTE_ENCODE_REDUCE_EN
        w0 = 8'h00; w1 = 8'h00; we = 1'b0;
`else
        w0 = 8'h01; w1 = 8'h0D; we = 1'b1;
`endif
        poly = '0;
        poly[15:0] = 16'd3329;
        fill_expected;
        run_stream(1'b0, 1'b0);
        check_stream("range", 385);
        total++;
        if (got[0] !== w0 || got[1] !== w1) begin
            bad++;
            $display("FAIL range_bytes got=%02h,%02h want=%02h,%02h", got[0], got[1], w0, w1);
        end
        total++;
        if (err1 !== we) begin
            bad++;
            $display("FAIL range_err_first got=%b want=%b", err1, we);
        end
        tick; tick;
        total++;
        if (err_range !== we) begin
            bad++;
            $display("FAIL range_err_sticky got=%b want=%b", err_range, we);
        end
        poly = '0;
        fill_expected;
        run_stream(1'b0, 1'b0);
        total++;
        if (err1 !== 1'b0) begin
            bad++;
            $display("FAIL range_err_clear got=%b want=0", err1);
        end
    endtask

    task automatic test_midop_reset;
        bit saw_done = 0;
        set_ramp;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (99) tick;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_byte, out_last, busy, done, err_range} !== 13'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%013b want=0",
                     {out_valid, out_byte, out_last, busy, done, err_range});
        end
        repeat (3) begin
            tick;
            if (done !== 1'b0) saw_done = 1;
        end
        rst = 1'b0;
        repeat (3) begin
            tick;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL midreset_no_done got activity after reset want none");
        end
        fill_expected;
        run_stream(1'b0, 1'b0);
        check_stream("after_reset", 385);
    endtask

    initial begin
        test_reset;
        test_zero;
        test_ramp;
        test_const3328;
        test_backpressure;
        test_range;
        test_midop_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
